// File: rtl/ps2_defs_pkg.sv
// Shared PS/2 definitions: write-path FSM states, default timing, command bytes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ps2_defs;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAITIDLE,
        DONE
    } ps2State_t;

    // Default timing in CLOCK cycles at 50 MHz.
    localparam int DEF_T100US    = 5000;     // 100 us clock inhibit
    localparam int DEF_T_SETUP   = 50;       // 1 us data-low setup before clock release
    localparam int DEF_T_TIMEOUT = 750000;   // 15 ms max wait for a device clock edge

    localparam int CNT_W = 20;               // holds DEF_T_TIMEOUT

    // Common host/device command bytes.
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ACK      = 8'hFA;

    // Frame after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [9:0] buildFrame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_clk_sync.sv
// Two-flop synchroniser for the PS/2 clock line plus a falling-edge strobe.
// Latency: level 2 cycles; falling-edge strobe 1 cycle after the pin falls.
// Backpressure: none; free-running sampler.
//
// Ports:
//   CLOCK, RESET : system clock, async active-low reset (flops reset high = idle line)
//   iPin         : raw PS/2 clock pin
//   oLevel       : synchronised level
//   oH2L         : one-cycle pulse on a high-to-low transition
module ps2_clk_sync (
    input  logic CLOCK,
    input  logic RESET,
    input  logic iPin,
    output logic oLevel,
    output logic oH2L
);

    logic F1;
    logic F2;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            F1 <= 1'b1;
            F2 <= 1'b1;
        end else begin
            F1 <= iPin;
            F2 <= F1;
        end
    end

    assign oLevel = F2;
    assign oH2L   = F2 & ~F1;

endmodule

// File: rtl/ps2_write_funcmod.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, 10 bits, sample device ACK.
// Latency: T100US + T_SETUP cycles of request, then paced by the device clock; oTrig 1 cycle after idle lines.
// Backpressure: iEn accepted only in IDLE; requests while oBusy are dropped, no queue.
//
// Ports:
//   CLOCK, RESET     : system clock, async active-low reset (pins released asynchronously)
//   PS2_CLK, PS2_DAT : open-drain PS/2 lines, driven 0 or Z only
//   iEn, iData       : start request and command byte, captured on accept
//   oTrig, oErr      : end-of-transaction pulse; oErr=1 for missing ACK or timeout
//   oBusy            : high from accept through the oTrig cycle
module ps2_write_funcmod
    import ps2_defs::*;
#(
    parameter int T100US    = DEF_T100US,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_TIMEOUT = DEF_T_TIMEOUT
) (
    input  logic       CLOCK,
    input  logic       RESET,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    input  logic       iEn,
    input  logic [7:0] iData,
    output logic       oTrig,
    output logic       oErr,
    output logic       oBusy
);

    localparam logic [CNT_W-1:0] LIM_INH = CNT_W'(T100US - 1);
    localparam logic [CNT_W-1:0] LIM_SET = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LIM_TO  = CNT_W'(T_TIMEOUT - 1);

    ps2State_t        state, stateN;
    logic [CNT_W-1:0] cnt, cntN;
    logic [3:0]       bitIdx, bitIdxN;
    logic [9:0]       frame, frameN;
    logic             ackOk, ackOkN;
    logic             clkLow, clkLowN;
    logic             datLow, datLowN;
    logic             timedOut;

    logic             clkLvl;
    logic             clkH2L;
    logic [1:0]       datSync;

    ps2_clk_sync uClkSync (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iPin   (PS2_CLK),
        .oLevel (clkLvl),
        .oH2L   (clkH2L)
    );

    // Data line only needs a level (ACK sample, idle detect).
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) datSync <= 2'b11;
        else        datSync <= {datSync[0], PS2_DAT};
    end

    // Drive flops reset low, so the pins float the instant RESET asserts.
    assign PS2_CLK = clkLow ? 1'b0 : 1'bz;
    assign PS2_DAT = datLow ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            bitIdx <= '0;
            frame  <= '0;
            ackOk  <= 1'b0;
            clkLow <= 1'b0;
            datLow <= 1'b0;
        end else begin
            state  <= stateN;
            cnt    <= cntN;
            bitIdx <= bitIdxN;
            frame  <= frameN;
            ackOk  <= ackOkN;
            clkLow <= clkLowN;
            datLow <= datLowN;
        end
    end

    always_comb begin
        stateN   = state;
        cntN     = cnt;
        bitIdxN  = bitIdx;
        frameN   = frame;
        ackOkN   = ackOk;
        clkLowN  = clkLow;
        datLowN  = datLow;
        // A device edge in the same cycle as the limit still counts as activity.
        timedOut = (cnt == LIM_TO) && !clkH2L;

        case (state)
            IDLE: begin
                clkLowN = 1'b0;
                datLowN = 1'b0;
                if (iEn) begin
                    frameN  = buildFrame(iData);
                    cntN    = '0;
                    bitIdxN = '0;
                    ackOkN  = 1'b0;
                    clkLowN = 1'b1;
                    stateN  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == LIM_INH) begin
                    cntN    = '0;
                    datLowN = 1'b1;          // start bit
                    stateN  = REQ;
                end else begin
                    cntN = cnt + 1'b1;
                end
            end
            REQ: begin
                if (cnt == LIM_SET) begin
                    cntN    = '0;
                    clkLowN = 1'b0;          // hand the clock to the device
                    bitIdxN = '0;
                    stateN  = BITS;
                end else begin
                    cntN = cnt + 1'b1;
                end
            end
            BITS, ACK, WAITIDLE: begin
                cntN = clkH2L ? '0 : cnt + 1'b1;
                if (timedOut) begin
                    cntN    = '0;
                    clkLowN = 1'b0;
                    datLowN = 1'b0;
                    ackOkN  = 1'b0;
                    stateN  = DONE;
                end else if (state == BITS) begin
                    if (clkH2L) begin
                        datLowN = ~frame[0];
                        frameN  = {1'b1, frame[9:1]};
                        bitIdxN = bitIdx + 4'd1;
                        if (bitIdx == 4'd9) stateN = ACK;
                    end
                end else if (state == ACK) begin
                    if (clkH2L) begin
                        ackOkN = ~datSync[1];
                        stateN = WAITIDLE;
                    end
                end else begin
                    if (clkLvl && datSync[1]) stateN = DONE;
                end
            end
            DONE: begin
                clkLowN = 1'b0;
                datLowN = 1'b0;
                stateN  = IDLE;
            end
            default: begin
                clkLowN = 1'b0;
                datLowN = 1'b0;
                stateN  = IDLE;
            end
        endcase
    end

    assign oTrig = (state == DONE);
    assign oErr  = (state == DONE) && !ackOk;
    assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_ps2_write_funcmod.sv
// Self-checking bench for ps2_write_funcmod with a PS/2 device model on open-drain lines.
// Latency: timeline expectations derived from the timing parameters and device release points.
// Backpressure: exercises requests dropped while busy and a mid-frame reset.
module tb_ps2_write_funcmod;
    import ps2_defs::*;

    localparam int T100US    = 600;
    localparam int T_SETUP   = 50;
    localparam int T_TIMEOUT = 4000;
    localparam int HALF      = 50;       // device clock half period in CLOCK cycles
    localparam int BIG       = 32'h7fffffff;

    logic       CLOCK;
    logic       RESET;
    logic       iEn;
    logic [7:0] iData;
    logic       oTrig;
    logic       oErr;
    logic       oBusy;
    wire        PS2_CLK;
    wire        PS2_DAT;

    logic devClkLow;
    logic devDatLow;

    pullup (PS2_CLK);
    pullup (PS2_DAT);
    assign PS2_CLK = devClkLow ? 1'b0 : 1'bz;
    assign PS2_DAT = devDatLow ? 1'b0 : 1'bz;

    ps2_write_funcmod #(
        .T100US    (T100US),
        .T_SETUP   (T_SETUP),
        .T_TIMEOUT (T_TIMEOUT)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .iEn     (iEn),
        .iData   (iData),
        .oTrig   (oTrig),
        .oErr    (oErr),
        .oBusy   (oBusy)
    );

    initial CLOCK = 1'b0;
    always #10 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Model of the transaction in flight.
    int nChecks = 0;
    int nFail   = 0;
    bit open    = 1'b0;
    bit expErr  = 1'b0;
    int accA    = 0;
    int winLo   = BIG;
    int winHi   = BIG;
    int trigCount = 0;
    int trigCyc   = 0;
    int dd;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkRange(input string name, input int act, input int lo, input int hi);
        nChecks++;
        if (act < lo || act > hi) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // Per-cycle comparison against the timeline model.
    always @(posedge CLOCK) begin
        #2;
        if (RESET) begin
            if (open) begin
                dd = cyc - accA;
                if (dd < T100US) begin
                    chk("inhibit_clk", PS2_CLK, 0);
                    chk("inhibit_dat", PS2_DAT, 1);
                end else if (dd < T100US + T_SETUP) begin
                    chk("request_clk", PS2_CLK, 0);
                    chk("request_dat", PS2_DAT, 0);
                end else if (dd == T100US + T_SETUP) begin
                    chk("release_clk", PS2_CLK, 1);
                    chk("release_dat", PS2_DAT, 0);
                end
                if (oTrig) begin
                    chkRange("trig_window", cyc, winLo, winHi);
                    chk("trig_err", oErr, expErr);
                    chk("trig_busy", oBusy, 1);
                    trigCount++;
                    trigCyc = cyc;
                    open = 1'b0;
                end else begin
                    chk("busy_open", oBusy, 1);
                end
            end else begin
                chk("idle_busy", oBusy, 0);
                chk("idle_trig", oTrig, 0);
                chk("idle_clk", PS2_CLK, 1);
                chk("idle_dat", PS2_DAT, 1);
            end
        end
    end

    task automatic startTx(input logic [7:0] d, input bit err);
        @(negedge CLOCK);
        iData  = d;
        iEn    = 1'b1;
        accA   = cyc + 1;
        winLo  = BIG;
        winHi  = BIG;
        expErr = err;
        open   = 1'b1;
        @(negedge CLOCK);
        iEn   = 1'b0;
        iData = ~d;      // must not disturb the captured frame
    endtask

    // Device: wait for request-to-send, clock nPulses bits, optional ACK on pulse 11.
    task automatic devFrame(input bit giveAck, input int nPulses, output logic [9:0] seen);
        int guard;
        seen  = '0;
        guard = 0;
        while (!(PS2_CLK == 1'b1 && PS2_DAT == 1'b0) && guard < 4 * (T100US + T_SETUP)) begin
            @(negedge CLOCK);
            guard++;
        end
        chk("request_seen", (guard < 4 * (T100US + T_SETUP)) ? 1 : 0, 1);
        waitCyc(HALF);
        for (int i = 0; i < nPulses && i < 10; i++) begin
            devClkLow = 1'b1;
            waitCyc(HALF);
            devClkLow = 1'b0;
            waitCyc(1);
            seen[i] = PS2_DAT;
            if (nPulses > i + 1) waitCyc(HALF - 1);
        end
        if (nPulses == 11) begin
            devDatLow = giveAck;
            waitCyc(5);
            devClkLow = 1'b1;
            waitCyc(HALF);
            winLo = cyc + 1;
            winHi = cyc + 6;
            devClkLow = 1'b0;
            devDatLow = 1'b0;
        end
    endtask

    task automatic waitDone(input int budget);
        int g;
        g = 0;
        while (open && g < budget) begin
            @(negedge CLOCK);
            g++;
        end
        chk("trig_seen", open ? 0 : 1, 1);
        open = 1'b0;
    endtask

    // Hand-computed frames {stop, odd parity, data}.
    logic [7:0] vecData  [4] = '{CMD_ENABLE, 8'h00, 8'hFF, 8'h01};
    logic [9:0] vecFrame [4] = '{10'h2F4, 10'h300, 10'h3FF, 10'h201};

    initial begin
        logic [9:0] seen;
        int tc0;
        RESET     = 1'b0;
        iEn       = 1'b0;
        iData     = 8'h00;
        devClkLow = 1'b0;
        devDatLow = 1'b0;
        waitCyc(5);
        chk("reset_trig", oTrig, 0);
        chk("reset_err", oErr, 0);
        chk("reset_busy", oBusy, 0);
        chk("reset_clk", PS2_CLK, 1);
        chk("reset_dat", PS2_DAT, 1);
        RESET = 1'b1;
        waitCyc(5);

        // Normal frames with ACK.
        for (int v = 0; v < 4; v++) begin
            tc0 = trigCount;
            startTx(vecData[v], 1'b0);
            devFrame(1'b1, 11, seen);
            waitDone(200);
            chk($sformatf("frame_%02h", vecData[v]), seen, vecFrame[v]);
            chk("trig_count", trigCount - tc0, 1);
            waitCyc(20);
        end

        // No ACK on the 11th clock.
        startTx(CMD_ENABLE, 1'b1);
        devFrame(1'b0, 11, seen);
        waitDone(200);
        chk("noack_frame", seen, 10'h2F4);
        waitCyc(20);

        // Device never clocks.
        startTx(8'hAA, 1'b1);
        winLo = accA + T100US + T_SETUP + T_TIMEOUT - 2;
        winHi = accA + T100US + T_SETUP + T_TIMEOUT + 2;
        waitDone(T100US + T_SETUP + T_TIMEOUT + 100);
        chkRange("timeout_latency", trigCyc - accA, 4648, 4652);
        waitCyc(20);

        // Request while busy is dropped; iData change mid-frame is ignored.
        tc0 = trigCount;
        startTx(8'h5A, 1'b0);
        fork
            devFrame(1'b1, 11, seen);
            begin
                waitCyc(T100US + T_SETUP + 8 * HALF);
                iEn   = 1'b1;
                iData = 8'h00;
                waitCyc(1);
                iEn   = 1'b0;
            end
        join
        waitDone(200);
        chk("busy_frame", seen, 10'h35A);
        waitCyc(2 * T100US);
        chk("busy_single_trig", trigCount - tc0, 1);

        // Reset during bit 4 of a 0x00 frame (host holding data low).
        tc0 = trigCount;
        startTx(8'h00, 1'b0);
        devFrame(1'b1, 5, seen);
        chk("abort_bits", seen[4:0], 0);
        RESET = 1'b0;
        #1;
        chk("abort_clk", PS2_CLK, 1);
        chk("abort_dat", PS2_DAT, 1);
        chk("abort_busy", oBusy, 0);
        chk("abort_trig", oTrig, 0);
        open = 1'b0;
        waitCyc(4);
        RESET = 1'b1;
        waitCyc(10);
        chk("abort_no_trig", trigCount - tc0, 0);

        startTx(CMD_SET_RATE, 1'b0);
        devFrame(1'b1, 11, seen);
        waitDone(200);
        chk("frame_f3", seen, 10'h3F3);
        waitCyc(20);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", nChecks, nFail);
        $fatal(1, "watchdog");
    end

endmodule
